// File: rtl/muladd_issue_ctrl.sv
// Issue sequencer feeding one vector_muladd from activation/weight/bias RAMs and collecting results.
// Build option: define MUL_ISSUE_BUBBLE_EN to insert one idle beat after every end-of-product beat.
module muladd_issue_ctrl #(
    parameter int CPF      = 4,
    parameter int DIN_DW   = 16,
    parameter int WW       = 16,
    parameter int BIAS_DW  = 16,
    parameter int DOUT_DW  = 8,
    parameter int IN_BEATS = 16,
    parameter int OUT_NUM  = 10,
    parameter int DIN_AW   = 4,
    parameter int W_AW     = 8,
    parameter int B_AW     = 4,
    parameter int PIPE_LAT = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  din_rd_en_o,
    output logic [DIN_AW-1:0]     din_rd_addr_o,
    input  logic [DIN_DW*CPF-1:0] din_rd_data_i,
    output logic                  w_rd_en_o,
    output logic [W_AW-1:0]       w_rd_addr_o,
    input  logic [WW*CPF-1:0]     w_rd_data_i,
    output logic                  b_rd_en_o,
    output logic [B_AW-1:0]       b_rd_addr_o,
    input  logic [BIAS_DW-1:0]    b_rd_data_i,
    output logic                  op_din_en_o,
    output logic                  op_din_eop_o,
    output logic [DIN_DW*CPF-1:0] op_din_o,
    output logic [WW*CPF-1:0]     op_weight_o,
    output logic [BIAS_DW-1:0]    op_bias_o,
    input  logic [DOUT_DW-1:0]    op_dout_i,
    output logic                  res_valid_o,
    output logic [B_AW-1:0]       res_addr_o,
    output logic [DOUT_DW-1:0]    res_data_o,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [DIN_AW-1:0] LAST_BEAT   = DIN_AW'(IN_BEATS - 1);
    localparam logic [B_AW-1:0]   LAST_NEURON = B_AW'(OUT_NUM - 1);
    localparam bit                SINGLE_BEAT = (IN_BEATS == 1);
`ifdef MUL_ISSUE_BUBBLE_EN
    localparam bit                BUBBLE_EN   = 1'b1;
`else
    localparam bit                BUBBLE_EN   = 1'b0;
`endif

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  din_rd_en_q;
    logic                  w_rd_en_q;
    logic                  b_rd_en_q;
    logic                  bubble_q;
    logic [DIN_AW-1:0]     beat_q;
    logic [B_AW-1:0]       neuron_q;
    logic [W_AW-1:0]       w_addr_q;
    logic                  op_din_en_q;
    logic                  op_din_eop_q;
    logic [PIPE_LAT-1:0]   eop_dly_q;
    logic [B_AW-1:0]       res_cnt_q;
    logic                  res_hit;

    // The muladd stream has no backpressure: op_din_en_o alone qualifies a beat,
    // and op_dout_i is taken exactly PIPE_LAT cycles after each op_din_eop_o.
    assign res_hit = eop_dly_q[PIPE_LAT-1];

    // Counters hold the (neuron, beat) being read this cycle; rd_en is low only in a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            din_rd_en_q <= 1'b0;
            w_rd_en_q   <= 1'b0;
            b_rd_en_q   <= 1'b0;
            bubble_q    <= 1'b0;
            beat_q      <= '0;
            neuron_q    <= '0;
            w_addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_ISSUE;
                        busy_q      <= 1'b1;
                        din_rd_en_q <= 1'b1;
                        w_rd_en_q   <= 1'b1;
                        b_rd_en_q   <= SINGLE_BEAT;
                        bubble_q    <= 1'b0;
                        beat_q      <= '0;
                        neuron_q    <= '0;
                        w_addr_q    <= '0;
                    end
                end
                S_ISSUE: begin
                    if (bubble_q) begin
                        bubble_q    <= 1'b0;
                        din_rd_en_q <= 1'b1;
                        w_rd_en_q   <= 1'b1;
                        b_rd_en_q   <= SINGLE_BEAT;
                    end else if (beat_q == LAST_BEAT) begin
                        if (neuron_q == LAST_NEURON) begin
                            state_q     <= S_DRAIN;
                            din_rd_en_q <= 1'b0;
                            w_rd_en_q   <= 1'b0;
                            b_rd_en_q   <= 1'b0;
                        end else begin
                            beat_q      <= '0;
                            neuron_q    <= neuron_q + B_AW'(1);
                            w_addr_q    <= w_addr_q + W_AW'(1);
                            din_rd_en_q <= !BUBBLE_EN;
                            w_rd_en_q   <= !BUBBLE_EN;
                            b_rd_en_q   <= SINGLE_BEAT && !BUBBLE_EN;
                            bubble_q    <= BUBBLE_EN;
                        end
                    end else begin
                        beat_q    <= beat_q + DIN_AW'(1);
                        w_addr_q  <= w_addr_q + W_AW'(1);
                        b_rd_en_q <= (beat_q + DIN_AW'(1) == LAST_BEAT);
                    end
                end
                S_DRAIN: begin
                    if (res_hit && (res_cnt_q == LAST_NEURON)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    beat_q   <= '0;
                    neuron_q <= '0;
                    w_addr_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stream flags trail the read strobes by one cycle so they line up with RAM data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_din_en_q  <= 1'b0;
            op_din_eop_q <= 1'b0;
            eop_dly_q    <= '0;
            res_cnt_q    <= '0;
        end else begin
            op_din_en_q  <= din_rd_en_q;
            op_din_eop_q <= din_rd_en_q && (beat_q == LAST_BEAT);
            eop_dly_q[0] <= op_din_eop_q;
            for (int i = 1; i < PIPE_LAT; i++) begin
                eop_dly_q[i] <= eop_dly_q[i-1];
            end
            if ((state_q == S_IDLE) && start_i) begin
                res_cnt_q <= '0;
            end else if (res_hit) begin
                res_cnt_q <= res_cnt_q + B_AW'(1);
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign din_rd_en_o   = din_rd_en_q;
    assign din_rd_addr_o = beat_q;
    assign w_rd_en_o     = w_rd_en_q;
    assign w_rd_addr_o   = w_addr_q;
    assign b_rd_en_o     = b_rd_en_q;
    assign b_rd_addr_o   = neuron_q;
    assign op_din_en_o   = op_din_en_q;
    assign op_din_eop_o  = op_din_eop_q;
    assign op_din_o      = din_rd_data_i;
    assign op_weight_o   = w_rd_data_i;
    assign op_bias_o     = b_rd_data_i;
    assign res_valid_o   = res_hit;
    assign res_addr_o    = res_cnt_q;
    assign res_data_o    = res_hit ? op_dout_i : '0;
    assign dbg_state_o   = state_q;

endmodule
